// File: rtl/display_scan_ctrl.sv
// Scan controller for an 8x8 dot matrix and a 4-digit seven-segment display.
// One prescaler drives both the row scan and the digit scan. The matrix frame
// is double-buffered and swapped only at a frame boundary, so a displayed
// frame never tears. Score digits are BCD-decoded and can blink on request.
module display_scan_ctrl #(
    parameter int SCAN_DIV     = 8192,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clkF,
    input  logic        reset,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [15:0] digit_in,
    input  logic        digit_load,
    input  logic        blank_en,
    output logic [2:0]  scanout,
    output logic [7:0]  segout,
    output logic [1:0]  scanout7,
    output logic [7:0]  segout7,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_row;
    logic [1:0]    r_dig;
    logic [63:0]   r_front;
    logic [63:0]   r_back;
    logic          r_pending;
    logic [15:0]   r_digits;
    logic [FW-1:0] r_fcnt;
    logic          r_phase;
    logic          r_frame_done;

    logic          w_tick;
    logic          w_bound;
    logic [3:0]    w_nib;
    logic [7:0]    w_seg_dec;

    assign w_tick  = (r_cnt == CNT_MAX);
    // Frame boundary: the step that takes the row from 7 back to 0.
    assign w_bound = w_tick && (r_row == 3'd7);

    // Prescaler: counts 0..SCAN_DIV-1 and wraps, one tick per scan step.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + 1'b1;
    end

    // Row and digit advance together on each tick; both wrap naturally.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_dig <= '0;
        end else if (w_tick) begin
            r_row <= r_row + 3'd1;
            r_dig <= r_dig + 2'd1;
        end
    end

    // One-cycle pulse following the row 7 -> 0 edge.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset) r_frame_done <= 1'b0;
        else       r_frame_done <= w_bound;
    end

    // Double buffer: accept into back when free, promote to front at the boundary.
    // Swap needs pending and accept needs !pending, so they are exclusive.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset) begin
            r_front   <= '1;
            r_back    <= '1;
            r_pending <= 1'b0;
        end else if (w_bound && r_pending) begin
            r_front   <= r_back;
            r_pending <= 1'b0;
        end else if (frame_valid && !r_pending) begin
            r_back    <= frame_in;
            r_pending <= 1'b1;
        end
    end

    // Score digits are captured whenever loaded; no handshake.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset)           r_digits <= '0;
        else if (digit_load) r_digits <= digit_in;
    end

    // Blink: count frame boundaries while enabled and flip phase on each wrap.
    always_ff @(posedge clkF or posedge reset) begin
        if (reset) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (!blank_en) begin
            r_fcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_bound) begin
            if (r_fcnt == FCNT_MAX) begin
                r_fcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_fcnt  <= r_fcnt + 1'b1;
            end
        end
    end

    // BCD to active-low segments; non-decimal codes blank the digit.
    always_comb begin
        w_nib = r_digits[{r_dig, 2'b00} +: 4];
        case (w_nib)
            4'd0:    w_seg_dec = 8'hC0;
            4'd1:    w_seg_dec = 8'hF9;
            4'd2:    w_seg_dec = 8'hA4;
            4'd3:    w_seg_dec = 8'hB0;
            4'd4:    w_seg_dec = 8'h99;
            4'd5:    w_seg_dec = 8'h92;
            4'd6:    w_seg_dec = 8'h82;
            4'd7:    w_seg_dec = 8'hF8;
            4'd8:    w_seg_dec = 8'h80;
            4'd9:    w_seg_dec = 8'h98;
            default: w_seg_dec = 8'hFF;
        endcase
    end

    assign scanout     = r_row;
    assign scanout7    = r_dig;
    assign segout      = r_front[{r_row, 3'b000} +: 8];
    assign segout7     = r_phase ? 8'hFF : w_seg_dec;
    assign frame_ready = !r_pending;
    assign frame_done  = r_frame_done;

endmodule
